// File: rtl/calc_seq_unit_if.sv
// calc_seq_unit_if
// Request/result channel bundle for the sequential calculator.
//   in_valid / in_ready   : request handshake carrying A, B, op
//   A, B                  : unsigned operands, WIDTH bits
//   op                    : 00 add, 01 subtract, 10 multiply, 11 divide
//   out_valid / out_ready : result handshake carrying result, divide_by_zero
//   result                : 2*WIDTH-bit operation result
//   divide_by_zero        : divide requested with B == 0
// master = request driver / result consumer, slave = the calculator.
interface calc_seq_unit_if #(
  parameter int WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [1:0]           op;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  logic                 divide_by_zero;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, result, divide_by_zero
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, result, divide_by_zero
  );
endinterface

// File: rtl/calc_seq_unit.sv
// calc_seq_unit
// Handshaked arithmetic responder: one request per transaction, add and
// subtract in a single step, multiply by iterative shift-add (LSB first),
// divide by iterative restoring division (MSB first).
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : calc_seq_unit_if.slave (request and result channels)
module calc_seq_unit #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  calc_seq_unit_if.slave bus
);

  localparam int RES_W = 2 * WIDTH;
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = IDX_W + 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [1:0]         op_q;
  logic [CNT_W-1:0]   count;
  logic [RES_W-1:0]   acc;
  logic [RES_W-1:0]   acc_next;
  logic [RES_W-1:0]   result_q;
  logic               dbz_q;

  logic               accept;
  logic               last_iter;
  logic [IDX_W-1:0]   bit_idx;
  logic [RES_W-1:0]   mul_addend;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;

  assign accept    = bus.in_valid && (state == IDLE);
  assign last_iter = (state == EXEC) && (count == CNT_W'(WIDTH - 1));
  assign bit_idx   = count[IDX_W-1:0];

  assign bus.result         = result_q;
  assign bus.divide_by_zero = dbz_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake outputs are pure state decodes, so in_ready and out_valid can
  // never be high together and in_valid has no combinational path to out_valid.
  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          if ((bus.op == OP_MUL) || ((bus.op == OP_DIV) && (bus.B != '0))) begin
            state_next = EXEC;
          end else begin
            state_next = DONE;
          end
        end
      end
      EXEC: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One iteration of the shared accumulator.
  // Multiply: acc is the running product; add A shifted by the bit position
  // when the current multiplier bit is set.
  // Divide: acc holds {remainder, quotient-in-progress}. The remainder shifted
  // left with the next dividend bit is acc[RES_W-1:WIDTH-1]; subtracting B with
  // one spare bit tells us from the borrow whether to restore. After WIDTH
  // steps acc is exactly {remainder, quotient}.
  always_comb begin
    mul_addend = RES_W'(a_q) << bit_idx;
    div_shift  = acc[RES_W-1:WIDTH-1];
    div_diff   = div_shift - {1'b0, b_q};
    acc_next   = acc;
    if (op_q == OP_MUL) begin
      if (b_q[bit_idx]) begin
        acc_next = acc + mul_addend;
      end
    end else begin
      if (!div_diff[WIDTH]) begin
        acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Operands are captured only on the accepting edge; single-step results are
  // written straight away, iterative ones on the last EXEC cycle, so result
  // is stable for the whole of DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      count    <= '0;
      acc      <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= bus.A;
            b_q   <= bus.B;
            op_q  <= bus.op;
            count <= '0;
            dbz_q <= 1'b0;
            case (bus.op)
              OP_ADD: result_q <= RES_W'(bus.A) + RES_W'(bus.B);
              OP_SUB: result_q <= RES_W'(bus.A) - RES_W'(bus.B);
              OP_MUL: acc      <= '0;
              default: begin
                acc <= RES_W'(bus.A);
                if (bus.B == '0) begin
                  result_q <= '0;
                  dbz_q    <= 1'b1;
                end
              end
            endcase
          end
        end
        EXEC: begin
          acc   <= acc_next;
          count <= count + CNT_W'(1);
          if (last_iter) begin
            result_q <= acc_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
